// File: rtl/ghost_mover.sv
// ghost_mover: accepts ghost directions, checks walls/edges and animates tile moves (GHOST_TUNNEL_WRAP_EN enables horizontal tunnel wrap)
module ghost_mover #(
  parameter int COORD_W = 6,
  parameter int MAP_W = 28,
  parameter int MAP_H = 31,
  parameter int SUB_STEPS = 8,
  parameter int SUB_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic [COORD_W-1:0] intPosX,
  input  logic [COORD_W-1:0] intPosY,
  input  logic dirValid,
  input  logic [1:0] dirToMove,
  output logic dirReady,
  input  logic canMoveU,
  input  logic canMoveR,
  input  logic canMoveD,
  input  logic canMoveL,
  input  logic update,
  output logic [COORD_W-1:0] ghostPosX,
  output logic [COORD_W-1:0] ghostPosY,
  output logic [SUB_W-1:0] subOffset,
  output logic [1:0] heading,
  output logic moving,
  output logic tileDone
);
  typedef enum logic {IDLE, MOVE} state_t;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_STEPS - 1);
  state_t state, state_n;
  logic [COORD_W-1:0] pos_x, pos_y, x_n, y_n;
  logic [SUB_W-1:0] sub;
  logic [1:0] head;
  logic done, legal, accept, arrive;
  assign dirReady = ~reset & (state == IDLE);
  assign moving = state == MOVE;
  assign ghostPosX = pos_x;
  assign ghostPosY = pos_y;
  assign subOffset = sub;
  assign heading = head;
  assign tileDone = done;
  always_comb begin
`ifdef GHOST_TUNNEL_WRAP_EN
    legal = dirToMove == 2'b00 ? canMoveU & (pos_y != '0) :
            dirToMove == 2'b01 ? canMoveR :
            dirToMove == 2'b10 ? canMoveD & (pos_y != Y_MAX) : canMoveL;
    x_n = head == 2'b01 ? (pos_x == X_MAX ? '0 : pos_x + 1'b1) :
          head == 2'b11 ? (pos_x == '0 ? X_MAX : pos_x - 1'b1) : pos_x;
`else
    legal = dirToMove == 2'b00 ? canMoveU & (pos_y != '0) :
            dirToMove == 2'b01 ? canMoveR & (pos_x != X_MAX) :
            dirToMove == 2'b10 ? canMoveD & (pos_y != Y_MAX) : canMoveL & (pos_x != '0);
    x_n = head == 2'b01 ? pos_x + 1'b1 : head == 2'b11 ? pos_x - 1'b1 : pos_x;
`endif
    y_n = head == 2'b00 ? pos_y - 1'b1 : head == 2'b10 ? pos_y + 1'b1 : pos_y;
    accept = dirValid & dirReady & legal;
    arrive = (state == MOVE) & update & (sub == SUB_LAST);
    state_n = state == IDLE ? (accept ? MOVE : IDLE) : (arrive ? IDLE : MOVE);
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= intPosX;
      pos_y <= intPosY;
      sub <= '0;
      head <= 2'b00;
      done <= 1'b0;
    end else begin
      done <= arrive;
      if (accept) head <= dirToMove;
      if ((state == MOVE) & update) sub <= arrive ? '0 : sub + 1'b1;
      if (arrive) begin
        pos_x <= x_n;
        pos_y <= y_n;
      end
    end
  end
endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: scoreboard bench pushing hand-computed snapshots checked by a negedge monitor
module tb_ghost_mover;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] intPosX = 6'd13, intPosY = 6'd23;
  logic dirValid = 1'b0, dirReady;
  logic [1:0] dirToMove = 2'b00;
  logic canMoveU = 1'b0, canMoveR = 1'b0, canMoveD = 1'b0, canMoveL = 1'b0;
  logic update = 1'b0;
  logic [5:0] ghostPosX, ghostPosY;
  logic [2:0] subOffset;
  logic [1:0] heading;
  logic moving, tileDone;
  int checks = 0, passed = 0;
  typedef struct {
    string name;
    logic [19:0] v;
  } exp_t;
  exp_t q[$];
  ghost_mover dut (
    .clk(clk), .reset(reset), .intPosX(intPosX), .intPosY(intPosY),
    .dirValid(dirValid), .dirToMove(dirToMove), .dirReady(dirReady),
    .canMoveU(canMoveU), .canMoveR(canMoveR), .canMoveD(canMoveD), .canMoveL(canMoveL),
    .update(update), .ghostPosX(ghostPosX), .ghostPosY(ghostPosY),
    .subOffset(subOffset), .heading(heading), .moving(moving), .tileDone(tileDone)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [19:0] got;
      e = q.pop_front();
      got = {ghostPosX, ghostPosY, subOffset, heading, moving, dirReady, tileDone};
      checks++;
      if (got === e.v) passed++;
      else $display("FAIL %s: got x=%0d y=%0d sub=%0d head=%0d mv=%0b rdy=%0b done=%0b, want x=%0d y=%0d sub=%0d head=%0d mv=%0b rdy=%0b done=%0b",
        e.name, got[19:14], got[13:8], got[7:5], got[4:3], got[2], got[1], got[0],
        e.v[19:14], e.v[13:8], e.v[7:5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
    end
  end
  task automatic tick(input string nm, input logic [5:0] ex, input logic [5:0] ey, input logic [2:0] es,
                      input logic [1:0] eh, input logic em, input logic er, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm;
    e.v = {ex, ey, es, eh, em, er, ed};
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask
  task automatic set_dir(input logic [1:0] d, input logic ok);
    dirToMove = d;
    canMoveU = ok & (d == 2'b00);
    canMoveR = ok & (d == 2'b01);
    canMoveD = ok & (d == 2'b10);
    canMoveL = ok & (d == 2'b11);
  endtask
  task automatic do_reset(input logic [5:0] x, input logic [5:0] y);
    intPosX = x;
    intPosY = y;
    reset = 1'b1;
    tick("reset", x, y, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick("post_reset", x, y, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic run_move(input string nm, input logic [1:0] d, input logic [5:0] sx, input logic [5:0] sy,
                          input logic [5:0] ex, input logic [5:0] ey);
    set_dir(d, 1'b1);
    dirValid = 1'b1;
    update = 1'b1;
    tick({nm, "_accept"}, sx, sy, 3'd0, d, 1'b1, 1'b0, 1'b0);
    dirValid = 1'b0;
    for (int i = 1; i < 8; i++) tick({nm, "_step"}, sx, sy, 3'(i), d, 1'b1, 1'b0, 1'b0);
    tick({nm, "_arrive"}, ex, ey, 3'd0, d, 1'b0, 1'b1, 1'b1);
    update = 1'b0;
    tick({nm, "_settle"}, ex, ey, 3'd0, d, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic drop(input string nm, input logic [1:0] d, input logic ok, input logic [5:0] x,
                      input logic [5:0] y, input logic [1:0] h);
    set_dir(d, ok);
    dirValid = 1'b1;
    tick({nm, "_drop"}, x, y, 3'd0, h, 1'b0, 1'b1, 1'b0);
    dirValid = 1'b0;
    update = 1'b1;
    tick({nm, "_idle_upd"}, x, y, 3'd0, h, 1'b0, 1'b1, 1'b0);
    tick({nm, "_idle_upd"}, x, y, 3'd0, h, 1'b0, 1'b1, 1'b0);
    update = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    #1;
    tick("reset_hold", 6'd13, 6'd23, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    do_reset(6'd13, 6'd23);
    run_move("left", 2'b11, 6'd13, 6'd23, 6'd12, 6'd23);
    drop("up_wall", 2'b00, 1'b0, 6'd12, 6'd23, 2'b11);
    set_dir(2'b10, 1'b1);
    dirValid = 1'b1;
    tick("hold_accept", 6'd12, 6'd23, 3'd0, 2'b10, 1'b1, 1'b0, 1'b0);
    update = 1'b1;
    for (int i = 1; i < 8; i++) begin
      set_dir(2'(i), i[0]);
      tick("hold_step", 6'd12, 6'd23, 3'(i), 2'b10, 1'b1, 1'b0, 1'b0);
    end
    tick("hold_arrive", 6'd12, 6'd24, 3'd0, 2'b10, 1'b0, 1'b1, 1'b1);
    set_dir(2'b01, 1'b1);
    tick("b2b_accept", 6'd12, 6'd24, 3'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    dirValid = 1'b0;
    for (int i = 1; i < 6; i++) tick("abort_step", 6'd12, 6'd24, 3'(i), 2'b01, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick("abort_reset", 6'd13, 6'd23, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick("abort_after", 6'd13, 6'd23, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick("abort_after", 6'd13, 6'd23, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    update = 1'b0;
    do_reset(6'd0, 6'd5);
`ifdef GHOST_TUNNEL_WRAP_EN
    run_move("wrap_left", 2'b11, 6'd0, 6'd5, 6'd27, 6'd5);
    run_move("wrap_right", 2'b01, 6'd27, 6'd5, 6'd0, 6'd5);
`else
    drop("edge_left", 2'b11, 1'b1, 6'd0, 6'd5, 2'b00);
    do_reset(6'd27, 6'd5);
    drop("edge_right", 2'b01, 1'b1, 6'd27, 6'd5, 2'b00);
`endif
    do_reset(6'd27, 6'd0);
    drop("edge_up", 2'b00, 1'b1, 6'd27, 6'd0, 2'b00);
    do_reset(6'd5, 6'd30);
    drop("edge_down", 2'b10, 1'b1, 6'd5, 6'd30, 2'b00);
    run_move("up", 2'b00, 6'd5, 6'd30, 6'd5, 6'd29);
    run_move("right", 2'b01, 6'd5, 6'd29, 6'd6, 6'd29);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
